// File: rtl/adc_spi_responder_pkg.sv
// Shared constants and FSM state type for the ADC serial configuration responder.
// Optional readback: define ADC_SPI_READBACK_EN to compile the readout shift path.
package adc_spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 5;

    localparam logic [ADDR_W-1:0] REG_CTRL = 8'h00;
    localparam int CTRL_READOUT_BIT = 0;
    localparam int CTRL_SOFTRST_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/adc_spi_responder_if.sv
// Serial pin bundle between the ADC register block (master) and the ADC (slave).
// There is no valid/ready handshake: a transfer is framed by adc_sen low, bits
// move on adc_sclk rising edges, and readback data changes on falling edges.
interface adc_spi_if;
    logic adc_sclk;
    logic adc_sdata;
    logic adc_sen;
    logic adc_reset;
    logic adc_sdout;
    logic adc_sdout_oe;

    modport master (
        output adc_sclk, adc_sdata, adc_sen, adc_reset,
        input  adc_sdout, adc_sdout_oe
    );

    modport slave (
        input  adc_sclk, adc_sdata, adc_sen, adc_reset,
        output adc_sdout, adc_sdout_oe
    );
endinterface

// File: rtl/adc_spi_responder_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus rise/fall pulses.
// The pulses are one clk cycle wide and appear in the cycle the synchronized
// level changes; RESET_VAL sets the idle level so reset causes no false edge.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchronizer chain and one-cycle-delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// Behavioural SPI-slave register file standing in for the ADC configuration port.
// Oversamples the serial pins on clk_usb, decodes 16-bit A/D frames, keeps a
// register array with soft reset, and optionally shifts register contents back
// out when ADC_SPI_READBACK_EN is defined (otherwise adc_sdout/oe stay 0).
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int pREG_DEPTH   = 32,
    parameter int pSYNC_STAGES = 2
) (
    input  logic                    clk_usb,
    input  logic                    reset_n,
    adc_spi_if.slave                spi,
    output logic [8*pREG_DEPTH-1:0] reg_flat,
    output logic                    frame_done,
    output logic                    frame_error,
    output state_t                  dbg_state
);

    logic sclk_level, sclk_rise, sclk_fall;
    logic sen_level, sen_rise, sen_fall;
    logic rst_level, rst_rise, rst_fall;
    logic [pSYNC_STAGES-1:0] sdata_sync;
    logic sdata_s;

    sync_edge #(.STAGES(pSYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk_usb), .rst_n(reset_n), .din(spi.adc_sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge #(.STAGES(pSYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sen (
        .clk(clk_usb), .rst_n(reset_n), .din(spi.adc_sen),
        .level(sen_level), .rise(sen_rise), .fall(sen_fall)
    );

    sync_edge #(.STAGES(pSYNC_STAGES), .RESET_VAL(1'b0)) u_sync_rst (
        .clk(clk_usb), .rst_n(reset_n), .din(spi.adc_reset),
        .level(rst_level), .rise(rst_rise), .fall(rst_fall)
    );

    // Data pin only needs to be stable when the sclk rise pulse arrives.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) sdata_sync <= '0;
        else          sdata_sync <= {sdata_sync[pSYNC_STAGES-2:0], spi.adc_sdata};
    end
    assign sdata_s = sdata_sync[pSYNC_STAGES-1];

    state_t              state, state_n;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shift_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wr_data, wr_data_ctrl;
    logic                commit, frame_err_n, capture;
    logic                addr_in_range, wr_allowed, wr_en, softrst_n, softrst_pend;
    logic [DATA_W-1:0]   regs [pREG_DEPTH];

    assign capture       = sclk_rise && !sen_level && (state == ST_ADDR || state == ST_DATA);
    assign wr_data       = {shift_q[DATA_W-2:0], sdata_s};
    assign addr_in_range = int'(addr_q) < pREG_DEPTH;
    assign wr_en         = commit && addr_in_range && wr_allowed;
    assign softrst_n     = wr_en && (addr_q == REG_CTRL) && wr_data[CTRL_SOFTRST_BIT];
    assign dbg_state     = state;

    // FSM state register; a synchronized adc_reset forces IDLE.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n)       state <= ST_IDLE;
        else if (rst_level) state <= ST_IDLE;
        else                state <= state_n;
    end

    // Next-state decode, commit strobe and abort detection.
    always_comb begin
        state_n     = state;
        commit      = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            ST_IDLE: if (sen_fall) state_n = ST_ADDR;
            ST_ADDR: begin
                if (sen_level) begin
                    state_n     = ST_IDLE;
                    frame_err_n = (bit_cnt != '0);
                end else if (sclk_rise && bit_cnt == 5'd7) begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (sen_level) begin
                    state_n     = ST_IDLE;
                    frame_err_n = 1'b1;
                end else if (sclk_rise && bit_cnt == 5'd15) begin
                    state_n = ST_DONE;
                    commit  = 1'b1;
                end
            end
            ST_DONE: if (sen_level) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Bit counter, shift register, latched address and result pulses.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt     <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else if (rst_level) begin
            bit_cnt     <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_done  <= commit;
            frame_error <= frame_err_n;
            if (state == ST_IDLE || sen_fall)
                bit_cnt <= '0;
            else if (sclk_rise && !sen_level && bit_cnt != 5'(FRAME_W))
                bit_cnt <= bit_cnt + 5'd1;
            if (capture) begin
                shift_q <= {shift_q[DATA_W-2:0], sdata_s};
                if (state == ST_ADDR && bit_cnt == 5'd7)
                    addr_q <= {shift_q[DATA_W-2:0], sdata_s};
            end
        end
    end

    // Control register never stores the self-clearing soft-reset bit.
    always_comb begin
        wr_data_ctrl                   = wr_data;
        wr_data_ctrl[CTRL_SOFTRST_BIT] = 1'b0;
    end

    // Register array: hardware/soft reset clears all, otherwise commit writes.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            regs         <= '{default: '0};
            softrst_pend <= 1'b0;
        end else if (rst_level || softrst_pend) begin
            regs         <= '{default: '0};
            softrst_pend <= 1'b0;
        end else begin
            softrst_pend <= softrst_n;
            for (int i = 0; i < pREG_DEPTH; i++) begin
                if (wr_en && addr_q == 8'(i))
                    regs[i] <= (addr_q == REG_CTRL) ? wr_data_ctrl : wr_data;
            end
        end
    end

    // Flatten the register array for observation.
    always_comb begin
        reg_flat = '0;
        for (int i = 0; i < pREG_DEPTH; i++)
            reg_flat[8*i +: 8] = regs[i];
    end

`ifdef ADC_SPI_READBACK_EN
    localparam int IDX_W = (pREG_DEPTH > 1) ? $clog2(pREG_DEPTH) : 1;

    logic              readout;
    logic [DATA_W-1:0] rd_data, out_sh;
    logic              sdout_q, oe_q;
    logic              unused_sync;

    assign readout    = regs[int'(REG_CTRL)][CTRL_READOUT_BIT];
    assign wr_allowed = !readout || (addr_q == REG_CTRL);
    assign rd_data    = addr_in_range ? regs[addr_q[IDX_W-1:0]] : '0;
    assign unused_sync = ^{sclk_level, rst_rise, rst_fall};

    // Readback shifter: load on the first falling edge of the data phase, then
    // shift one bit per falling edge; released when the frame ends.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            out_sh  <= '0;
            sdout_q <= 1'b0;
            oe_q    <= 1'b0;
        end else if (rst_level || state == ST_IDLE || sen_rise) begin
            out_sh  <= '0;
            sdout_q <= 1'b0;
            oe_q    <= 1'b0;
        end else if (sclk_fall && state == ST_DATA && !sen_level) begin
            if (!oe_q) begin
                if (readout && bit_cnt == 5'd8) begin
                    oe_q    <= 1'b1;
                    sdout_q <= rd_data[DATA_W-1];
                    out_sh  <= {rd_data[DATA_W-2:0], 1'b0};
                end
            end else begin
                sdout_q <= out_sh[DATA_W-1];
                out_sh  <= {out_sh[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign spi.adc_sdout    = sdout_q;
    assign spi.adc_sdout_oe = oe_q;
`else
    logic unused_sync;

    assign wr_allowed       = 1'b1;
    assign unused_sync      = ^{sclk_level, sclk_fall, sen_rise, rst_rise, rst_fall};
    assign spi.adc_sdout    = 1'b0;
    assign spi.adc_sdout_oe = 1'b0;
`endif

endmodule
